pixel_writer: RTL

Sink end of the shader pixel stream. Accepts write_pixel strobes carrying x/y/RGB888 and buffers them in a small FIFO. Converts each pixel to a linear framebuffer address and RGB565 word, then issues req/ack writes to the framebuffer memory port. Sits between the shader and the SRAM/VGA framebuffer controller. Signals end-of-frame once all pixels of the frame are committed.

---
 rtl/pixel_pkg.sv | 35 +++
 rtl/pixel_fifo.sv | 56 +++++
 rtl/pixel_writer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared types for the pixel writer: default resolution, the queued pixel
// record, the RGB888 -> RGB565 packer and the write FSM state encoding.
// Optional feature macro: PIXEL_WRITER_CLEAR_EN (adds the CLEAR state).
package pixel_pkg;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rgb565;
  } pixel_t;

  // Keep the top bits of each channel: 5 red, 6 green, 5 blue.
  function automatic logic [15:0] rgb565(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

`ifdef PIXEL_WRITER_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding accepted pixels until the write FSM can
// hand them to the framebuffer. Full/empty come from a registered count.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  pixel_t din,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  pixel_t        storage [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign dout    = storage[rd_ptr];

  // Storage array needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Sink for the shader pixel stream: clips, queues, converts to a linear
// framebuffer address plus RGB565, and writes through a req/ack port.
// Optional feature macro: PIXEL_WRITER_CLEAR_EN (screen clear with clear_start).
module pixel_writer
  import pixel_pkg::*;
#(
  parameter int H_RES  = H_RES_DEFAULT,
  parameter int V_RES  = V_RES_DEFAULT,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_pixel,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  input  logic              frame_end,
  output logic              pixel_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
`ifdef PIXEL_WRITER_CLEAR_EN
  input  logic              clear_start,
  input  logic [15:0]       clear_color,
`endif
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       clip_count
);

  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  state_t            state;
  state_t            state_next;
  pixel_t            fifo_in;
  pixel_t            fifo_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              in_range;
  logic              push;
  logic              pop;
  logic              load_pixel;
  logic              clear_go;
  logic              frame_pend;
  logic              done_cond;
  logic [ADDR_W-1:0] addr_calc;

  assign in_range = ({22'd0, x_pixel} < H_RES) && ({22'd0, y_pixel} < V_RES);
  assign push     = write_pixel && pixel_ready && in_range;
  assign mem_req  = (state != IDLE);

  assign fifo_in.x      = x_pixel;
  assign fifo_in.y      = y_pixel;
  assign fifo_in.rgb565 = rgb565(R, G, B);

  assign addr_calc = ADDR_W'(fifo_out.y) * H_RES_A + ADDR_W'(fifo_out.x);

`ifdef PIXEL_WRITER_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  logic load_clear;
  logic clear_step;

  assign clear_go    = clear_start && (state == IDLE);
  assign pixel_ready = !fifo_full && (state != CLEAR);
`else
  assign clear_go    = 1'b0;
  assign pixel_ready = !fifo_full;
`endif

  assign done_cond = frame_pend && fifo_empty && (state == IDLE) && !push && !clear_go;

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_in),
    .dout  (fifo_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and pop/load decisions; a pending write never advances without ack.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_pixel = 1'b0;
`ifdef PIXEL_WRITER_CLEAR_EN
    load_clear = 1'b0;
    clear_step = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef PIXEL_WRITER_CLEAR_EN
        if (clear_go) begin
          load_clear = 1'b1;
          state_next = CLEAR;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          load_pixel = 1'b1;
          state_next = WRITE;
        end
`else
        if (!fifo_empty) begin
          pop        = 1'b1;
          load_pixel = 1'b1;
          state_next = WRITE;
        end
`endif
      end
      WRITE: begin
        if (mem_ack) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            load_pixel = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
`ifdef PIXEL_WRITER_CLEAR_EN
      CLEAR: begin
        if (mem_ack) begin
          if (mem_addr == LAST_ADDR) state_next = IDLE;
          else                       clear_step = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Memory-stage address/data registers, held while a request waits for ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load_pixel) begin
      mem_addr  <= addr_calc;
      mem_wdata <= fifo_out.rgb565;
    end
`ifdef PIXEL_WRITER_CLEAR_EN
    else if (load_clear) begin
      mem_addr  <= '0;
      mem_wdata <= clear_color;
    end else if (clear_step) begin
      mem_addr  <= mem_addr + 1'b1;
    end
`endif
  end

  // Status: clipped pixels are counted, in-range pixels refused while full set overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      clip_count <= '0;
    end else begin
      if (write_pixel && in_range && !pixel_ready) overflow <= 1'b1;
      if (write_pixel && !in_range && (clip_count != 16'hFFFF))
        clip_count <= clip_count + 16'd1;
    end
  end

  // End-of-frame latch; a new frame_end wins over clearing so it is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_pend <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_cond;
      if (frame_end)      frame_pend <= 1'b1;
      else if (done_cond) frame_pend <= 1'b0;
    end
  end

endmodule
